interrupt_controller: RTL

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

---
 rtl/interrupt_controller.sv | 82 ++++++++
 1 files changed

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronized edge/level interrupt capture with fixed-priority presentation to a CPU
module interrupt_controller #(
  parameter int NUM_CH = 24,
  parameter int SYNC_STAGES = 2,
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_CH-1:0]   irq_in,
  input  logic [NUM_CH-1:0]   irq_en,
  input  logic [2*NUM_CH-1:0] irq_mode,
  input  logic                irq_ack,
  input  logic                irq_done,
  output logic                irq_req,
  output logic [ID_W-1:0]     irq_id,
  output logic [NUM_CH-1:0]   pending,
  output logic                busy
);
  localparam int WARM = SYNC_STAGES + 1;
  localparam int CW = $clog2(WARM + 1);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t stateReg, stateNext;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0] syncReg;
  logic [NUM_CH-1:0] histReg, syncLast, evt, elig, ackClr;
  logic [CW-1:0] warmCnt;
  logic warmDone, anyElig;
  logic [ID_W-1:0] idReg, winner;
  assign syncLast = syncReg[SYNC_STAGES-1];
  assign warmDone = warmCnt == CW'(WARM);
  assign elig = pending & irq_en;
  assign anyElig = |elig;
  assign irq_req = stateReg == REQ;
  assign busy = stateReg == SERVICE;
  assign irq_id = idReg;
  // synchronizer chain, history flop and post-reset warm-up counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      syncReg <= '0;
      histReg <= '0;
      warmCnt <= '0;
    end else begin
      syncReg <= {syncReg[SYNC_STAGES-2:0], irq_in};
      histReg <= syncLast;
      warmCnt <= warmDone ? warmCnt : warmCnt + 1'b1;
    end
  end
  // per-channel event decode from synchronized value versus history
  always_comb begin
    evt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      evt[i] = irq_mode[2*i+:2] == 2'b00 ? (syncLast[i] & ~histReg[i]) :
               irq_mode[2*i+:2] == 2'b01 ? (~syncLast[i] & histReg[i]) :
               irq_mode[2*i+:2] == 2'b10 ? (syncLast[i] ^ histReg[i]) : syncLast[i];
    end
  end
  // lowest eligible index wins
  always_comb begin
    winner = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (elig[i]) winner = ID_W'(i);
    end
  end
  // next state and the acknowledge clear of the presented channel
  always_comb begin
    stateNext = (stateReg == IDLE && anyElig) ? REQ :
                (stateReg == REQ && irq_ack) ? SERVICE :
                (stateReg == SERVICE && irq_done) ? IDLE : stateReg;
    ackClr = (stateReg == REQ && irq_ack) ? (NUM_CH'(1) << idReg) : '0;
  end
  // state, latched id and pending register; a new event overrides the ack clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateReg <= IDLE;
      idReg <= '0;
      pending <= '0;
    end else begin
      stateReg <= stateNext;
      idReg <= (stateReg == IDLE && anyElig) ? winner : idReg;
      pending <= (pending & ~ackClr) | (evt & irq_en & {NUM_CH{warmDone}});
    end
  end
endmodule
